// File: rtl/rps_pkg.sv
// Shared types and constants for the rock/scissor/paper display path:
// choice codes, plot colours, frame size, sequencer states and pipeline stage.
package rps_pkg;

  localparam logic [1:0] ROCK    = 2'b00;
  localparam logic [1:0] SCISSOR = 2'b01;
  localparam logic [1:0] PAPER   = 2'b10;

  localparam logic [2:0] COL_FG_C = 3'b111;
  localparam logic [2:0] COL_FG_U = 3'b000;
  localparam logic [2:0] COL_BG   = 3'b010;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW_C,
    S_DRAW_U,
    S_FLUSH,
    S_DONE
  } state_t;

  // One in-flight fetch travelling alongside the ROM read latency.
  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [6:0] y;
    logic       panel;
  } pix_t;

  // The 11 code has no image of its own and shows paper.
  function automatic logic [1:0] norm_choice(input logic [1:0] c);
    return (c == 2'b11) ? PAPER : c;
  endfunction

endpackage

// File: rtl/rps_scan_counter.sv
// Raster counter for one panel: px runs fastest, py steps on px wrap,
// last flags the final pixel so the caller can switch panels.
module rps_scan_counter #(
  parameter int W = 80,
  parameter int H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [7:0] px,
  output logic [6:0] py,
  output logic       last
);

  logic px_end;
  logic py_end;

  assign px_end = (px == 8'(W - 1));
  assign py_end = (py == 7'(H - 1));
  assign last   = px_end && py_end;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px <= '0;
      py <= '0;
    end else if (clr) begin
      px <= '0;
      py <= '0;
    end else if (en) begin
      if (px_end) begin
        px <= '0;
        py <= py_end ? '0 : py + 7'd1;
      end else begin
        px <= px + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rps_draw_sequencer.sv
// Redraws the computer (left) then user (right) choice panels, fetching one
// ROM pixel per cycle and delaying x/y/plot to line up with ROM data.
module rps_draw_sequencer #(
  parameter int PANEL_W  = 80,
  parameter int PANEL_H  = 120,
  parameter int SCREEN_W = 160,
  parameter int ROM_LAT  = 1,
  parameter int ADDR_W   = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              go,
  input  logic [1:0]        choice_c,
  input  logic [1:0]        choice_u,
  output logic              busy,
  output logic              done,
  output logic [1:0]        rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_q,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot
);
  import rps_pkg::*;

  state_t      state, state_n;
  logic [1:0]  ch_c, ch_u;
  logic [1:0]  flush_cnt;
  logic        latch_go;
  logic        cnt_en, cnt_clr, last;
  logic [7:0]  px, x_abs;
  logic [6:0]  py;
  logic        fetch, panel;
  pix_t [ROM_LAT-1:0] pipe;
  pix_t        tail;

  rps_scan_counter #(.W(PANEL_W), .H(PANEL_H)) u_scan (
    .clk   (CLOCK_50),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .px    (px),
    .py    (py),
    .last  (last)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ch_c      <= 2'b00;
      ch_u      <= 2'b00;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_n;
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      if (latch_go) begin
        ch_c <= norm_choice(choice_c);
        ch_u <= norm_choice(choice_u);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    latch_go = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_n  = S_DRAW_C;
          latch_go = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      S_DRAW_C: begin
        cnt_en = 1'b1;
        if (last) state_n = S_DRAW_U;
      end
      S_DRAW_U: begin
        cnt_en = 1'b1;
        if (last) state_n = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_cnt == 2'(ROM_LAT - 1)) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign fetch   = (state == S_DRAW_C) || (state == S_DRAW_U);
  assign panel   = (state == S_DRAW_U);
  assign x_abs   = panel ? 8'(PANEL_W) + px : px;
  assign rom_sel = (state == S_DRAW_C) ? ch_c :
                   (state == S_DRAW_U) ? ch_u : 2'b00;

  logic [ADDR_W-1:0] y_ext, x_ext;
  assign y_ext = ADDR_W'(py);
  assign x_ext = ADDR_W'(x_abs);

  generate
    if (SCREEN_W == 160) begin : g_addr_shift
      assign rom_addr = (y_ext << 7) + (y_ext << 5) + x_ext;
    end else begin : g_addr_mul
      assign rom_addr = y_ext * ADDR_W'(SCREEN_W) + x_ext;
    end
  endgenerate

  // NOTE: this shift register is only a few flops deep, so it is reset: the
  // valid bits must clear at once to stop plotting when a draw is aborted.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= '{valid: fetch, x: x_abs, y: py, panel: panel};
      for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Colour stays combinational: rom_q arrives in the same cycle as the tail stage.
  assign tail   = pipe[ROM_LAT-1];
  assign plot   = tail.valid;
  assign x      = tail.x;
  assign y      = tail.y;
  assign colour = !tail.valid ? 3'b000   :
                  !rom_q      ? COL_BG   :
                  tail.panel  ? COL_FG_U : COL_FG_C;

endmodule

// File: tb/tb_rps_draw_sequencer.sv
// Runs a ROM_LAT=1 and a ROM_LAT=3 sequencer side by side from shared stimulus,
// each fed by an "odd address = 1" ROM model with matching latency.
module tb_rps_draw_sequencer;

  localparam int NPIX  = 9600;
  localparam int TOTAL = 19200;

  logic              clk = 1'b0;
  logic              reset, go;
  logic [1:0]        choice_c, choice_u;
  logic [1:0]        busy, done, plot, rom_q;
  logic [1:0][1:0]   rom_sel;
  logic [1:0][14:0]  rom_addr;
  logic [1:0][7:0]   x;
  logic [1:0][6:0]   y;
  logic [1:0][2:0]   colour;

  always #5 clk = ~clk;

  rps_draw_sequencer #(.ROM_LAT(1)) u_dut_l1 (
    .CLOCK_50(clk), .reset(reset), .go(go), .choice_c(choice_c), .choice_u(choice_u),
    .busy(busy[0]), .done(done[0]), .rom_sel(rom_sel[0]), .rom_addr(rom_addr[0]),
    .rom_q(rom_q[0]), .x(x[0]), .y(y[0]), .colour(colour[0]), .plot(plot[0])
  );

  rps_draw_sequencer #(.ROM_LAT(3)) u_dut_l3 (
    .CLOCK_50(clk), .reset(reset), .go(go), .choice_c(choice_c), .choice_u(choice_u),
    .busy(busy[1]), .done(done[1]), .rom_sel(rom_sel[1]), .rom_addr(rom_addr[1]),
    .rom_q(rom_q[1]), .x(x[1]), .y(y[1]), .colour(colour[1]), .plot(plot[1])
  );

  logic       q1;
  logic [2:0] d3;
  always @(posedge clk) begin
    q1 <= rom_addr[0][0];
    d3 <= {d3[1:0], rom_addr[1][0]};
  end
  assign rom_q = {d3[2], q1};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  // Fetch index -> frame address: left panel first, then right panel.
  function automatic int exp_addr(input int c);
    int p;
    p = c % NPIX;
    return (p / 80) * 160 + ((c >= NPIX) ? 80 : 0) + (p % 80);
  endfunction

  logic [1:0] exp_sel_c, exp_sel_u;
  int cyc[2], plots[2], fetch_err[2], plot_err[2], post_err[2];
  int done_cnt[2], done_idx[2];
  int cap0[2], cap79[2], cap80[2], cap_last[2], cap_sel_c[2], cap_sel_u[2];
  logic [1:0] prev_busy, prev_done;
  int n, ex, ey, ecol;

  // Per-cycle scoreboard; cyc = 0 on the first busy cycle (= first fetch).
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (reset) begin
        prev_busy[l] = 1'b0;
        prev_done[l] = 1'b0;
      end else begin
        if (busy[l] && !prev_busy[l]) begin
          cyc[l] = 0; plots[l] = 0; fetch_err[l] = 0; plot_err[l] = 0;
          post_err[l] = 0; done_cnt[l] = 0; done_idx[l] = -1;
        end else if (busy[l]) begin
          cyc[l]++;
        end
        if (prev_done[l] && busy[l]) post_err[l]++;
        if (busy[l] && cyc[l] < TOTAL) begin
          if (int'(rom_addr[l]) != exp_addr(cyc[l]) ||
              rom_sel[l] != ((cyc[l] < NPIX) ? exp_sel_c : exp_sel_u)) fetch_err[l]++;
          if (cyc[l] == 0)         begin cap0[l] = int'(rom_addr[l]); cap_sel_c[l] = int'(rom_sel[l]); end
          if (cyc[l] == 79)        cap79[l] = int'(rom_addr[l]);
          if (cyc[l] == 80)        cap80[l] = int'(rom_addr[l]);
          if (cyc[l] == TOTAL - 1) begin cap_last[l] = int'(rom_addr[l]); cap_sel_u[l] = int'(rom_sel[l]); end
        end
        if (plot[l]) begin
          n = plots[l];
          if (!busy[l] || n >= TOTAL || cyc[l] != n + lat_of(l)) begin
            plot_err[l]++;
          end else begin
            ex   = (n % NPIX) % 80 + ((n >= NPIX) ? 80 : 0);
            ey   = (n % NPIX) / 80;
            ecol = (ex % 2 == 1) ? ((n < NPIX) ? 7 : 0) : 2;
            if (int'(x[l]) != ex || int'(y[l]) != ey || int'(colour[l]) != ecol) plot_err[l]++;
          end
          plots[l]++;
        end
        if (done[l]) begin
          done_cnt[l]++;
          done_idx[l] = cyc[l];
        end
        prev_busy[l] = busy[l];
        prev_done[l] = done[l];
      end
    end
  end

  task automatic check_run(input string tag);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("%s_l%0d_plots", tag, l), plots[l], TOTAL);
      check($sformatf("%s_l%0d_fetch_err", tag, l), fetch_err[l], 0);
      check($sformatf("%s_l%0d_plot_err", tag, l), plot_err[l], 0);
      check($sformatf("%s_l%0d_done_cnt", tag, l), done_cnt[l], 1);
      check($sformatf("%s_l%0d_done_idx", tag, l), done_idx[l], TOTAL + lat_of(l));
      check($sformatf("%s_l%0d_busy_after_done", tag, l), post_err[l], 0);
      check($sformatf("%s_l%0d_addr0", tag, l), cap0[l], 0);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] cc, input logic [1:0] cu,
                     input logic [1:0] esc, input logic [1:0] esu, input bit hold);
    int cnt;
    exp_sel_c = esc;
    exp_sel_u = esu;
    choice_c  = cc;
    choice_u  = cu;
    go        = 1'b1;
    tick();
    check({tag, "_busy_rise"}, int'(busy), 3);
    if (!hold) go = 1'b0;
    cnt = 0;
    while (!(done_cnt[0] == 1 && done_cnt[1] == 1 && busy == 2'b00) && cnt < 25000) begin
      if (hold && cyc[0] == 100)  begin choice_c = 2'b01; choice_u = 2'b00; end
      if (hold && cyc[0] == 1000) go = 1'b0;
      tick();
      cnt++;
    end
    if (cnt >= 25000) check({tag, "_timeout"}, 0, 1);
    choice_c = cc;
    choice_u = cu;
    tick();
    check_run(tag);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; go = 1'b1; choice_c = 2'b10; choice_u = 2'b01;
    exp_sel_c = 2'b00; exp_sel_u = 2'b00;

    for (int i = 0; i < 3; i++) begin
      tick();
      for (int l = 0; l < 2; l++) begin
        check($sformatf("rst_busy_l%0d", l), int'(busy[l]), 0);
        check($sformatf("rst_plot_l%0d", l), int'(plot[l]), 0);
        check($sformatf("rst_done_l%0d", l), int'(done[l]), 0);
        check($sformatf("rst_colour_l%0d", l), int'(colour[l]), 0);
      end
    end
    check("rst_addr", int'(rom_addr[0]), 0);
    check("rst_sel", int'(rom_sel[0]), 0);
    check("rst_xy", int'(x[0]) + int'(y[0]), 0);
    reset = 1'b0; go = 1'b0;
    tick();
    tick();

    run("base", 2'b00, 2'b10, 2'b00, 2'b10, 1'b0);
    check("base_addr_79_0", cap79[0], 79);
    check("base_addr_0_1", cap80[0], 160);
    check("base_addr_159_119", cap_last[0], 19199);
    check("base_done_l1", done_idx[0], 19201);
    check("base_done_l3", done_idx[1], 19203);

    run("hold_go", 2'b00, 2'b11, 2'b00, 2'b10, 1'b1);

    exp_sel_c = 2'b00; exp_sel_u = 2'b10;
    choice_c = 2'b00; choice_u = 2'b10;
    go = 1'b1;
    tick();
    go = 1'b0;
    cnt = 0;
    while (cyc[0] != 5000 && cnt < 6000) begin
      tick();
      cnt++;
    end
    check("mid_reached", cyc[0], 5000);
    check("mid_pre_plot", int'(plot[0]), 1);
    reset = 1'b1;
    #1;
    check("mid_plot", int'(plot), 0);
    check("mid_busy", int'(busy), 0);
    tick();
    check("mid_held_plot", int'(plot), 0);
    reset = 1'b0;
    tick();

    run("restart", 2'b11, 2'b01, 2'b10, 2'b01, 1'b0);
    check("lat3_sel_c_11", cap_sel_c[1], 2);
    check("lat3_sel_u", cap_sel_u[1], 1);
    check("lat3_done", done_idx[1], 19203);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
